// File: rtl/data_mem_arbiter_pkg.sv
// Shared CPU package: trap vectors, data-memory arbiter FSM encoding and owner type.
package data_mem_arbiter_pkg;

  localparam logic [31:0] ILLOP = 32'h8000_0004;
  localparam logic [31:0] XADR  = 32'h8000_0008;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CPU_ACC = 2'd1;
  localparam logic [1:0] ST_DMA_ACC = 2'd2;
  localparam logic [1:0] ST_ERR_ACK = 2'd3;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_t;

  function automatic logic isMisaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/data_mem_arbiter_prio.sv
// Winner selection for the data-memory arbiter: CPU by default, DMA when starved or alone.
module arb_prio
  import data_mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       i_cpu_req,
  input  logic       i_dma_req,
  input  logic [3:0] i_starve_cnt,
  output owner_t     o_winner
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  // Pick the requester that would be granted if the FSM is idle this cycle.
  always_comb begin
    o_winner = OWN_NONE;
    if (i_dma_req && ((i_starve_cnt == LIMIT) || !i_cpu_req))
      o_winner = OWN_DMA;
    else if (i_cpu_req)
      o_winner = OWN_CPU;
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port (CPU / DMA loader) arbiter in front of a single-ported data memory.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int LAT          = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ack,
  output logic        cpu_err,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_wr,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic [31:0] dma_rdata,
  output logic        dma_ack,
  output logic        dma_err,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [3:0] LAST_CNT = 4'(LAT - 1);
  localparam logic [3:0] LIMIT    = 4'(STARVE_LIMIT);

  logic [1:0]  r_state;
  owner_t      r_owner;
  logic        r_wr;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_cnt;
  logic [3:0]  r_starve;

  owner_t      w_winner;
  logic        w_grantWr;
  logic [31:0] w_grantAddr;
  logic [31:0] w_grantWdata;
  logic        w_inAccess;
  logic        w_lastCycle;
  logic        w_ack;
  logic        w_err;
  logic [31:0] w_rdata;

  arb_prio #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_arbPrio (
    .i_cpu_req   (cpu_req),
    .i_dma_req   (dma_req),
    .i_starve_cnt(r_starve),
    .o_winner    (w_winner)
  );

  // Route the winning requester's transfer fields toward the latch registers.
  always_comb begin
    w_grantWr    = cpu_wr;
    w_grantAddr  = cpu_addr;
    w_grantWdata = cpu_wdata;
    if (w_winner == OWN_DMA) begin
      w_grantWr    = dma_wr;
      w_grantAddr  = dma_addr;
      w_grantWdata = dma_wdata;
    end
  end

  // Main FSM: grant in IDLE, latch the transfer, count LAT access cycles, then return.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_owner <= OWN_NONE;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_winner != OWN_NONE) begin
            r_owner <= w_winner;
            r_wr    <= w_grantWr;
            r_addr  <= w_grantAddr;
            r_wdata <= w_grantWdata;
            r_cnt   <= '0;
            if (isMisaligned(w_grantAddr))
              r_state <= ST_ERR_ACK;
            else if (w_winner == OWN_DMA)
              r_state <= ST_DMA_ACC;
            else
              r_state <= ST_CPU_ACC;
          end
        end
        ST_CPU_ACC, ST_DMA_ACC: begin
          if (r_cnt == LAST_CNT) begin
            r_state <= ST_IDLE;
            r_owner <= OWN_NONE;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_owner <= OWN_NONE;
        end
      endcase
    end
  end

  // Starvation counter: counts CPU grants made while DMA is waiting, saturating at the limit.
  always_ff @(posedge clk) begin
    if (reset || !dma_req)
      r_starve <= '0;
    else if (r_state == ST_IDLE && w_winner == OWN_DMA)
      r_starve <= '0;
    else if (r_state == ST_IDLE && w_winner == OWN_CPU && r_starve != LIMIT)
      r_starve <= r_starve + 4'd1;
  end

  assign w_inAccess  = (r_state == ST_CPU_ACC) || (r_state == ST_DMA_ACC);
  assign w_lastCycle = w_inAccess && (r_cnt == LAST_CNT);

  // Memory strobes and the completion pulse; everything is forced quiet while reset is high.
  always_comb begin
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    w_ack     = 1'b0;
    w_err     = 1'b0;
    w_rdata   = '0;
    if (!reset) begin
      if (w_inAccess) begin
        mem_rd    = ~r_wr;
        mem_wr    = r_wr;
        mem_addr  = r_addr;
        mem_wdata = r_wdata;
      end
      if (w_lastCycle) begin
        w_ack   = 1'b1;
        w_rdata = r_wr ? 32'h0 : mem_rdata;
      end
      if (r_state == ST_ERR_ACK) begin
        w_ack = 1'b1;
        w_err = 1'b1;
      end
    end
  end

  // Steer the completion to the owner only; the other port sees zeros.
  always_comb begin
    cpu_ack   = 1'b0;
    cpu_err   = 1'b0;
    cpu_rdata = '0;
    dma_ack   = 1'b0;
    dma_err   = 1'b0;
    dma_rdata = '0;
    if (r_owner == OWN_CPU) begin
      cpu_ack   = w_ack;
      cpu_err   = w_err;
      cpu_rdata = w_rdata;
    end else if (r_owner == OWN_DMA) begin
      dma_ack   = w_ack;
      dma_err   = w_err;
      dma_rdata = w_rdata;
    end
  end

  assign cpu_stall = cpu_req & ~cpu_ack;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: three instances (LAT=1/SL=2, LAT=3/SL=4, LAT=4/SL=4) share stimulus.
module tb_data_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        cpuReq, cpuWr, dmaReq, dmaWr;
  logic [31:0] cpuAddr, cpuWdata, dmaAddr, dmaWdata;

  logic [31:0] cpuRdataA, dmaRdataA, memAddrA, memWdataA, memRdataA;
  logic        cpuAckA, cpuErrA, cpuStallA, dmaAckA, dmaErrA, memRdA, memWrA;
  logic [31:0] cpuRdataB, dmaRdataB, memAddrB, memWdataB, memRdataB;
  logic        cpuAckB, cpuErrB, cpuStallB, dmaAckB, dmaErrB, memRdB, memWrB;
  logic [31:0] cpuRdataC, dmaRdataC, memAddrC, memWdataC, memRdataC;
  logic        cpuAckC, cpuErrC, cpuStallC, dmaAckC, dmaErrC, memRdC, memWrC;

  int checks;
  int failures;

  // Memory contents: 0x10 holds 0xDEADBEEF, every other word is its address tagged with 0xC0DE.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEAD_BEEF : (a ^ 32'hC0DE_0000);
  endfunction

  assign memRdataA = memWord(memAddrA);
  assign memRdataB = memWord(memAddrB);
  assign memRdataC = memWord(memAddrC);

  data_mem_arbiter #(.LAT(1), .STARVE_LIMIT(2)) u_dutA (
    .clk(clk), .reset(reset),
    .cpu_req(cpuReq), .cpu_wr(cpuWr), .cpu_addr(cpuAddr), .cpu_wdata(cpuWdata),
    .cpu_rdata(cpuRdataA), .cpu_ack(cpuAckA), .cpu_err(cpuErrA), .cpu_stall(cpuStallA),
    .dma_req(dmaReq), .dma_wr(dmaWr), .dma_addr(dmaAddr), .dma_wdata(dmaWdata),
    .dma_rdata(dmaRdataA), .dma_ack(dmaAckA), .dma_err(dmaErrA),
    .mem_rd(memRdA), .mem_wr(memWrA), .mem_addr(memAddrA), .mem_wdata(memWdataA),
    .mem_rdata(memRdataA)
  );

  data_mem_arbiter #(.LAT(3), .STARVE_LIMIT(4)) u_dutB (
    .clk(clk), .reset(reset),
    .cpu_req(cpuReq), .cpu_wr(cpuWr), .cpu_addr(cpuAddr), .cpu_wdata(cpuWdata),
    .cpu_rdata(cpuRdataB), .cpu_ack(cpuAckB), .cpu_err(cpuErrB), .cpu_stall(cpuStallB),
    .dma_req(dmaReq), .dma_wr(dmaWr), .dma_addr(dmaAddr), .dma_wdata(dmaWdata),
    .dma_rdata(dmaRdataB), .dma_ack(dmaAckB), .dma_err(dmaErrB),
    .mem_rd(memRdB), .mem_wr(memWrB), .mem_addr(memAddrB), .mem_wdata(memWdataB),
    .mem_rdata(memRdataB)
  );

  data_mem_arbiter #(.LAT(4), .STARVE_LIMIT(4)) u_dutC (
    .clk(clk), .reset(reset),
    .cpu_req(cpuReq), .cpu_wr(cpuWr), .cpu_addr(cpuAddr), .cpu_wdata(cpuWdata),
    .cpu_rdata(cpuRdataC), .cpu_ack(cpuAckC), .cpu_err(cpuErrC), .cpu_stall(cpuStallC),
    .dma_req(dmaReq), .dma_wr(dmaWr), .dma_addr(dmaAddr), .dma_wdata(dmaWdata),
    .dma_rdata(dmaRdataC), .dma_ack(dmaAckC), .dma_err(dmaErrC),
    .mem_rd(memRdC), .mem_wr(memWrC), .mem_addr(memAddrC), .mem_wdata(memWdataC),
    .mem_rdata(memRdataC)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle's inputs on the falling edge, then let combinational outputs settle.
  task automatic applyStimulus(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                               input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd);
    @(negedge clk);
    cpuReq = cr; cpuWr = cw; cpuAddr = ca; cpuWdata = cd;
    dmaReq = dr; dmaWr = dw; dmaAddr = da; dmaWdata = dd;
    #1;
  endtask

  task automatic resetAll();
    @(negedge clk);
    reset = 1'b1;
    cpuReq = 1'b0; cpuWr = 1'b0; cpuAddr = '0; cpuWdata = '0;
    dmaReq = 1'b0; dmaWr = 1'b0; dmaAddr = '0; dmaWdata = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    cpuReq = 1'b1;
    #1;
    checks++; if (cpuAckA !== 1'b0) begin failures++; $display("[TB] FAIL rst_cpu_ack got=%b exp=0", cpuAckA); end
    checks++; if (memRdA !== 1'b0) begin failures++; $display("[TB] FAIL rst_mem_rd got=%b exp=0", memRdA); end
    checks++; if (memAddrA !== 32'h0) begin failures++; $display("[TB] FAIL rst_mem_addr got=%h exp=0", memAddrA); end
    checks++; if (cpuStallA !== 1'b1) begin failures++; $display("[TB] FAIL rst_cpu_stall got=%b exp=1", cpuStallA); end
    @(negedge clk);
    reset = 1'b0; cpuReq = 1'b0;
    #1;
    checks++; if ({memRdA, memWrA, cpuAckA, dmaAckA, cpuStallA} !== 5'b0) begin
      failures++; $display("[TB] FAIL idle_quiet got=%b exp=00000", {memRdA, memWrA, cpuAckA, dmaAckA, cpuStallA}); end
    checks++; if ({memAddrA, memWdataA} !== 64'h0) begin
      failures++; $display("[TB] FAIL idle_bus got=%h exp=0", {memAddrA, memWdataA}); end
  endtask

  task automatic test_cpu_read();
    resetAll();
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    checks++; if (memRdA !== 1'b0) begin failures++; $display("[TB] FAIL rd_grant_memrd got=%b exp=0", memRdA); end
    checks++; if (cpuStallA !== 1'b1) begin failures++; $display("[TB] FAIL rd_grant_stall got=%b exp=1", cpuStallA); end
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    checks++; if (memRdA !== 1'b1) begin failures++; $display("[TB] FAIL rd_memrd got=%b exp=1", memRdA); end
    checks++; if (memAddrA !== 32'h10) begin failures++; $display("[TB] FAIL rd_addr got=%h exp=00000010", memAddrA); end
    checks++; if (cpuAckA !== 1'b1) begin failures++; $display("[TB] FAIL rd_ack got=%b exp=1", cpuAckA); end
    checks++; if (cpuRdataA !== 32'hDEAD_BEEF) begin failures++; $display("[TB] FAIL rd_data got=%h exp=deadbeef", cpuRdataA); end
    checks++; if ({cpuErrA, cpuStallA, dmaAckA} !== 3'b0) begin
      failures++; $display("[TB] FAIL rd_side got=%b exp=000", {cpuErrA, cpuStallA, dmaAckA}); end
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    checks++; if ({memRdA, cpuAckA} !== 2'b0) begin failures++; $display("[TB] FAIL rd_after got=%b exp=00", {memRdA, cpuAckA}); end
  endtask

  task automatic test_cpu_write();
    resetAll();
    applyStimulus(1'b1, 1'b1, 32'h24, 32'h1234, 1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h24, 32'h1234, 1'b0, 1'b0, 32'h0, 32'h0);
    checks++; if ({memWrA, memRdA} !== 2'b10) begin failures++; $display("[TB] FAIL wr_strobes got=%b exp=10", {memWrA, memRdA}); end
    checks++; if ({memAddrA, memWdataA} !== {32'h24, 32'h1234}) begin
      failures++; $display("[TB] FAIL wr_bus got=%h exp=%h", {memAddrA, memWdataA}, {32'h24, 32'h1234}); end
    checks++; if (cpuAckA !== 1'b1) begin failures++; $display("[TB] FAIL wr_ack got=%b exp=1", cpuAckA); end
    checks++; if (cpuRdataA !== 32'h0) begin failures++; $display("[TB] FAIL wr_rdata got=%h exp=0", cpuRdataA); end
  endtask

  task automatic test_dma_write();
    logic expAck;
    resetAll();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h20, 32'h55AA);
    checks++; if ({memWrB, dmaAckB, cpuStallB} !== 3'b0) begin
      failures++; $display("[TB] FAIL dma_grant got=%b exp=000", {memWrB, dmaAckB, cpuStallB}); end
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h20, 32'h55AA);
      expAck = (k == 3);
      checks++; if ({memWrB, memRdB} !== 2'b10) begin
        failures++; $display("[TB] FAIL dma_strobes cyc=%0d got=%b exp=10", k, {memWrB, memRdB}); end
      checks++; if ({memAddrB, memWdataB} !== {32'h20, 32'h55AA}) begin
        failures++; $display("[TB] FAIL dma_bus cyc=%0d got=%h", k, {memAddrB, memWdataB}); end
      checks++; if (dmaAckB !== expAck) begin failures++; $display("[TB] FAIL dma_ack cyc=%0d got=%b exp=%b", k, dmaAckB, expAck); end
      checks++; if ({cpuStallB, cpuAckB, dmaRdataB} !== 34'h0) begin
        failures++; $display("[TB] FAIL dma_side cyc=%0d got=%h exp=0", k, {cpuStallB, cpuAckB, dmaRdataB}); end
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    checks++; if ({memWrB, dmaAckB} !== 2'b0) begin failures++; $display("[TB] FAIL dma_after got=%b exp=00", {memWrB, dmaAckB}); end
  endtask

  task automatic test_starvation();
    logic [11:0] expCpu;
    logic [11:0] expDma;
    expCpu = 12'h28A;
    expDma = 12'h820;
    resetAll();
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
      checks++; if (cpuAckA !== expCpu[i]) begin failures++; $display("[TB] FAIL starve_cpu_ack cyc=%0d got=%b exp=%b", i, cpuAckA, expCpu[i]); end
      checks++; if (dmaAckA !== expDma[i]) begin failures++; $display("[TB] FAIL starve_dma_ack cyc=%0d got=%b exp=%b", i, dmaAckA, expDma[i]); end
      checks++; if ((cpuAckA & dmaAckA) !== 1'b0) begin failures++; $display("[TB] FAIL starve_double_ack cyc=%0d got=1 exp=0", i); end
      if (i == 5) begin
        checks++; if (dmaRdataA !== 32'hC0DE_0020) begin failures++; $display("[TB] FAIL starve_dma_rdata got=%h exp=c0de0020", dmaRdataA); end
        checks++; if (cpuRdataA !== 32'h0) begin failures++; $display("[TB] FAIL starve_cpu_rdata got=%h exp=0", cpuRdataA); end
      end
    end
  endtask

  task automatic test_misaligned();
    resetAll();
    applyStimulus(1'b1, 1'b0, 32'h13, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    checks++; if ({cpuAckA, memRdA} !== 2'b0) begin failures++; $display("[TB] FAIL mis_grant got=%b exp=00", {cpuAckA, memRdA}); end
    applyStimulus(1'b1, 1'b0, 32'h13, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    checks++; if ({cpuAckA, cpuErrA} !== 2'b11) begin failures++; $display("[TB] FAIL mis_ack_err got=%b exp=11", {cpuAckA, cpuErrA}); end
    checks++; if (cpuRdataA !== 32'h0) begin failures++; $display("[TB] FAIL mis_rdata got=%h exp=0", cpuRdataA); end
    checks++; if ({memRdA, memWrA, memAddrA} !== 34'h0) begin failures++; $display("[TB] FAIL mis_mem got=%h exp=0", {memRdA, memWrA, memAddrA}); end
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    checks++; if ({cpuAckA, cpuErrA, memRdA} !== 3'b0) begin failures++; $display("[TB] FAIL mis_after got=%b exp=000", {cpuAckA, cpuErrA, memRdA}); end
  endtask

  task automatic test_reset_mid_access();
    logic expAck;
    resetAll();
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
    checks++; if (memRdC !== 1'b1) begin failures++; $display("[TB] FAIL mid_first_cycle got=%b exp=1", memRdC); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if ({memRdC, cpuAckC, dmaAckC} !== 3'b0) begin failures++; $display("[TB] FAIL mid_during_rst got=%b exp=000", {memRdC, cpuAckC, dmaAckC}); end
    @(negedge clk);
    reset = 1'b0; cpuReq = 1'b0; dmaReq = 1'b0;
    #1;
    checks++; if (u_dutC.r_starve !== 4'd0) begin failures++; $display("[TB] FAIL mid_starve got=%0d exp=0", u_dutC.r_starve); end
    for (int k = 0; k < 3; k++) begin
      if (k > 0) applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      checks++; if ({memRdC, cpuAckC} !== 2'b0) begin failures++; $display("[TB] FAIL mid_aborted cyc=%0d got=%b exp=00", k, {memRdC, cpuAckC}); end
    end
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      expAck = (k == 4);
      checks++; if (memRdC !== 1'b1) begin failures++; $display("[TB] FAIL mid_new_memrd cyc=%0d got=%b exp=1", k, memRdC); end
      checks++; if (cpuAckC !== expAck) begin failures++; $display("[TB] FAIL mid_new_ack cyc=%0d got=%b exp=%b", k, cpuAckC, expAck); end
      if (k == 4) begin
        checks++; if (cpuRdataC !== 32'hDEAD_BEEF) begin failures++; $display("[TB] FAIL mid_new_rdata got=%h exp=deadbeef", cpuRdataC); end
      end
    end
  endtask

  task automatic test_addr_change();
    logic expAck;
    resetAll();
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      expAck = (k == 3);
      checks++; if (memAddrB !== 32'h10) begin failures++; $display("[TB] FAIL latch_addr cyc=%0d got=%h exp=00000010", k, memAddrB); end
      checks++; if (cpuAckB !== expAck) begin failures++; $display("[TB] FAIL latch_ack cyc=%0d got=%b exp=%b", k, cpuAckB, expAck); end
      if (k == 3) begin
        checks++; if (cpuRdataB !== 32'hDEAD_BEEF) begin failures++; $display("[TB] FAIL latch_rdata got=%h exp=deadbeef", cpuRdataB); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] expRd;
    logic [8:0] expAck;
    expRd  = 9'h0EE;
    expAck = 9'h088;
    resetAll();
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      checks++; if (memRdB !== expRd[i]) begin failures++; $display("[TB] FAIL b2b_memrd cyc=%0d got=%b exp=%b", i, memRdB, expRd[i]); end
      checks++; if (cpuAckB !== expAck[i]) begin failures++; $display("[TB] FAIL b2b_ack cyc=%0d got=%b exp=%b", i, cpuAckB, expAck[i]); end
      checks++; if (cpuStallB !== ~expAck[i]) begin failures++; $display("[TB] FAIL b2b_stall cyc=%0d got=%b exp=%b", i, cpuStallB, ~expAck[i]); end
    end
  endtask

  // Safety net so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Scenario sequence.
  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    cpuReq = 1'b0; cpuWr = 1'b0; cpuAddr = '0; cpuWdata = '0;
    dmaReq = 1'b0; dmaWr = 1'b0; dmaAddr = '0; dmaWdata = '0;
    test_reset();
    test_cpu_read();
    test_cpu_write();
    test_dma_write();
    test_starvation();
    test_misaligned();
    test_reset_mid_access();
    test_addr_change();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter LAT, default 1, memory access cycles per transfer, legal range 1..15.
REQ-002 Parameter STARVE_LIMIT, default 4, consecutive CPU grants allowed while DMA waits, legal range 1..15.
REQ-003 clk  in  1  single clock, all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 cpu_req  in  1  CPU MEM-stage access request, held until cpu_ack.
REQ-006 cpu_wr  in  1  1 = write, 0 = read.
REQ-007 cpu_addr  in  32  byte address.
REQ-008 cpu_wdata  in  32  write data.
REQ-009 cpu_rdata  out  32  read data, valid while cpu_ack = 1.
REQ-010 cpu_ack  out  1  one-cycle completion pulse.
REQ-011 cpu_err  out  1  misaligned-access flag, valid with cpu_ack.
REQ-012 cpu_stall  out  1  pipeline freeze, = cpu_req & ~cpu_ack, combinational.
REQ-013 dma_req, dma_wr, dma_addr[31:0], dma_wdata[31:0]  in  UART-loader requester, same semantics as CPU port.
REQ-014 dma_rdata[31:0], dma_ack, dma_err  out  same semantics as CPU port.
REQ-015 mem_rd, mem_wr  out  1  DataMem strobes.
REQ-016 mem_addr[31:0], mem_wdata[31:0]  out  DataMem address and write data; mem_rdata[31:0]  in  DataMem read data, combinational from mem_addr.

Function
REQ-017 FSM states: IDLE, CPU_ACC, DMA_ACC, ERR_ACK.
REQ-018 IDLE with no request: all strobes 0, mem_addr/mem_wdata 0.
REQ-019 Arbitration happens only in IDLE; CPU wins by default.
REQ-020 DMA wins instead when dma_req = 1 and starve_cnt = STARVE_LIMIT, or when cpu_req = 0.
REQ-021 starve_cnt increments on each CPU grant while dma_req = 1, clears on DMA grant or when dma_req = 0, and saturates at STARVE_LIMIT.
REQ-022 Winner with addr[1:0] != 0 goes to ERR_ACK for one cycle: ack = 1, err = 1, rdata = 0, no mem strobe.
REQ-023 Aligned winner goes to CPU_ACC/DMA_ACC; the grant's addr, wdata and wr are latched at grant.
REQ-024 An access state lasts exactly LAT cycles, driving mem_rd = ~wr or mem_wr = wr on every cycle, with latched addr/wdata.
REQ-025 In the last access cycle, the owner's ack = 1 and rdata = mem_rdata (reads) or 0 (writes); the FSM then returns to IDLE.
REQ-026 Latency from request seen in IDLE to ack is LAT+1 cycles, and there is one IDLE cycle between back-to-back grants.
REQ-027 The non-owner's ack, err and rdata are 0; at most one ack is asserted per cycle.
REQ-028 A request deasserted before ack does not abort an access in progress; the access completes and ack still pulses.
REQ-029 Address or data changes on the requester side during an access are ignored, because the values are latched.
REQ-030 Simultaneous cpu_req and dma_req in IDLE with starve_cnt < STARVE_LIMIT grants CPU.

Reset
REQ-031 reset = 1 at a clock edge forces IDLE and starve_cnt = 0, and clears all latched fields.
REQ-032 During reset all outputs are 0, except cpu_stall, which follows REQ-012.
REQ-033 Reset mid-access aborts the access: strobes are 0 from the next cycle and no ack is issued.

Structure
REQ-034 FSM state encoding and the owner enum (NONE, CPU, DMA) reside in the shared CPU package, alongside the existing ILLOP/XADR vector constants.
REQ-035 One sub-module, arb_prio, is natural: combinational winner selection from cpu_req, dma_req and starve_cnt.
REQ-036 All other logic is flat: FSM, access-cycle counter, starvation counter and latched fields.

Verification
REQ-037 LAT=1: CPU read of 0x10 with memory word 0xDEADBEEF -> cycle 0 grant; cycle 1 mem_rd = 1, cpu_ack = 1, cpu_rdata = 0xDEADBEEF; cycle 2 IDLE.
REQ-038 LAT=3: DMA write of 0x55AA to 0x20 -> mem_wr high for 3 cycles at mem_addr 0x20, dma_ack in the 3rd cycle, cpu_stall = 0 throughout.
REQ-039 STARVE_LIMIT=2: cpu_req and dma_req both held high -> grants CPU, CPU, DMA, CPU, CPU, DMA; never two acks in one cycle.
REQ-040 CPU read of 0x13 -> cpu_ack = 1 and cpu_err = 1 on the cycle after the request, mem_rd never asserted, cpu_rdata = 0.
REQ-041 LAT=4: reset asserted in the 2nd access cycle -> strobes 0 from the next cycle, no ack, starve_cnt = 0; a new request afterwards completes normally.
REQ-042 cpu_addr changed from 0x10 to 0x40 mid-access -> mem_addr stays 0x10 until ack.
